// File: rtl/biriscv_fetch_queue.sv
// Instruction queue between fetch and decode: compacts valid slots of each fetch
// packet into a circular buffer and presents up to ISSUE_WIDTH in-order entries.
module biriscv_fetch_queue #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8,
  parameter int DEPTH_W     = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,

  input  logic                     fetch_in_valid_i,
  input  logic [32*FETCH_WIDTH-1:0] fetch_in_instr_i,
  input  logic [31:0]              fetch_in_pc_i,
  input  logic [FETCH_WIDTH-1:0]   fetch_in_mask_i,
  input  logic [FETCH_WIDTH-1:0]   fetch_in_pred_branch_i,
  input  logic                     fetch_in_fault_fetch_i,
  input  logic                     fetch_in_fault_page_i,
  output logic                     fetch_in_accept_o,

  input  logic                     flush_i,

  output logic [ISSUE_WIDTH-1:0]   issue_valid_o,
  output logic [32*ISSUE_WIDTH-1:0] issue_instr_o,
  output logic [32*ISSUE_WIDTH-1:0] issue_pc_o,
  output logic [ISSUE_WIDTH-1:0]   issue_pred_branch_o,
  output logic [ISSUE_WIDTH-1:0]   issue_fault_fetch_o,
  output logic [ISSUE_WIDTH-1:0]   issue_fault_page_o,
  input  logic [ISSUE_WIDTH-1:0]   issue_accept_i,

  output logic [DEPTH_W:0]         level_o
);

  localparam logic [DEPTH_W:0] DEPTH_L = (DEPTH_W+1)'(DEPTH);
  localparam logic [DEPTH_W:0] FETCH_L = (DEPTH_W+1)'(FETCH_WIDTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
    logic        fault_fetch;
    logic        fault_page;
  } entry_t;

  entry_t               mem_q [DEPTH];
  logic [DEPTH_W-1:0]   rd_ptr_q;
  logic [DEPTH_W-1:0]   wr_ptr_q;
  logic [DEPTH_W:0]     count_q;

  logic [FETCH_WIDTH-1:0] eff_mask;
  logic                   trunc_hit;
  logic [DEPTH_W-1:0]     wr_idx [FETCH_WIDTH];
  logic [DEPTH_W:0]       mask_cnt;
  logic                   fault_any;
  logic                   do_push;
  logic [DEPTH_W:0]       push_cnt;
  logic [DEPTH_W:0]       pop_cnt;
  logic                   pop_run;

  // Space check uses only the registered count, so a same-cycle pop never frees room.
  assign fetch_in_accept_o = (DEPTH_L - count_q) >= FETCH_L;
  assign fault_any         = fetch_in_fault_fetch_i | fetch_in_fault_page_i;
  assign do_push           = fetch_in_valid_i & fetch_in_accept_o & ~flush_i;
  assign level_o           = count_q;

  // Slots after the first valid predicted-taken slot are on the wrong path.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    eff_mask  = '0;
    trunc_hit = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!trunc_hit) begin
        eff_mask[i] = fetch_in_mask_i[i];
        trunc_hit   = fetch_in_mask_i[i] & fetch_in_pred_branch_i[i];
      end
    end
  end

  // Compaction: each kept slot lands at wr_ptr plus the number of kept slots below it.
  always_comb begin
    mask_cnt = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_idx[i] = wr_ptr_q + mask_cnt[DEPTH_W-1:0];
      mask_cnt  = mask_cnt + {{DEPTH_W{1'b0}}, eff_mask[i]};
    end
  end

  always_comb begin
    push_cnt = '0;
    if (do_push) begin
      push_cnt = fault_any ? (DEPTH_W+1)'(1) : mask_cnt;
    end
  end

  // Pop stops at the first slot that is not both valid and accepted.
  always_comb begin
    pop_cnt = '0;
    pop_run = 1'b1;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (pop_run && issue_valid_o[k] && issue_accept_i[k]) begin
        pop_cnt = pop_cnt + (DEPTH_W+1)'(1);
      end else begin
        pop_run = 1'b0;
      end
    end
  end

  // NOTE: storage is not reset; validity comes solely from count_q, which is.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      if (fault_any) begin
        mem_q[wr_ptr_q] <= '{instr:       32'h0,
                             pc:          fetch_in_pc_i,
                             pred:        1'b0,
                             fault_fetch: fetch_in_fault_fetch_i,
                             fault_page:  fetch_in_fault_page_i};
      end else begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          if (eff_mask[i]) begin
            mem_q[wr_idx[i]] <= '{instr:       fetch_in_instr_i[32*i +: 32],
                                  pc:          fetch_in_pc_i + 32'(4*i),
                                  pred:        fetch_in_pred_branch_i[i],
                                  fault_fetch: 1'b0,
                                  fault_page:  1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      rd_ptr_q <= rd_ptr_q + pop_cnt[DEPTH_W-1:0];
      wr_ptr_q <= wr_ptr_q + push_cnt[DEPTH_W-1:0];
      count_q  <= count_q + push_cnt - pop_cnt;
    end
  end

  for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_issue
    logic [DEPTH_W-1:0] rd_idx;
    assign rd_idx                     = rd_ptr_q + DEPTH_W'(k);
    assign issue_valid_o[k]           = count_q > (DEPTH_W+1)'(k);
    assign issue_instr_o[32*k +: 32]  = mem_q[rd_idx].instr;
    assign issue_pc_o[32*k +: 32]     = mem_q[rd_idx].pc;
    assign issue_pred_branch_o[k]     = mem_q[rd_idx].pred;
    assign issue_fault_fetch_o[k]     = mem_q[rd_idx].fault_fetch;
    assign issue_fault_page_o[k]      = mem_q[rd_idx].fault_page;
  end

  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= DEPTH_L);

endmodule

// File: tb/tb_biriscv_fetch_queue.sv
// Self-checking bench for biriscv_fetch_queue: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_biriscv_fetch_queue;

  localparam int FW    = 2;
  localparam int IW    = 2;
  localparam int DEPTH = 8;
  localparam int DW    = 3;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
    logic        ff;
    logic        fp;
  } ent_t;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              fetch_in_valid_i;
  logic [32*FW-1:0]  fetch_in_instr_i;
  logic [31:0]       fetch_in_pc_i;
  logic [FW-1:0]     fetch_in_mask_i;
  logic [FW-1:0]     fetch_in_pred_branch_i;
  logic              fetch_in_fault_fetch_i;
  logic              fetch_in_fault_page_i;
  logic              fetch_in_accept_o;
  logic              flush_i;
  logic [IW-1:0]     issue_valid_o;
  logic [32*IW-1:0]  issue_instr_o;
  logic [32*IW-1:0]  issue_pc_o;
  logic [IW-1:0]     issue_pred_branch_o;
  logic [IW-1:0]     issue_fault_fetch_o;
  logic [IW-1:0]     issue_fault_page_o;
  logic [IW-1:0]     issue_accept_i;
  logic [DW:0]       level_o;

  int   vectors    = 0;
  int   miscompares = 0;
  ent_t mq[$];

  biriscv_fetch_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH), .DEPTH_W(DW)) dut (
    .clk_i                  (clk_i),
    .rst_ni                 (rst_ni),
    .fetch_in_valid_i       (fetch_in_valid_i),
    .fetch_in_instr_i       (fetch_in_instr_i),
    .fetch_in_pc_i          (fetch_in_pc_i),
    .fetch_in_mask_i        (fetch_in_mask_i),
    .fetch_in_pred_branch_i (fetch_in_pred_branch_i),
    .fetch_in_fault_fetch_i (fetch_in_fault_fetch_i),
    .fetch_in_fault_page_i  (fetch_in_fault_page_i),
    .fetch_in_accept_o      (fetch_in_accept_o),
    .flush_i                (flush_i),
    .issue_valid_o          (issue_valid_o),
    .issue_instr_o          (issue_instr_o),
    .issue_pc_o             (issue_pc_o),
    .issue_pred_branch_o    (issue_pred_branch_o),
    .issue_fault_fetch_o    (issue_fault_fetch_o),
    .issue_fault_page_o     (issue_fault_page_o),
    .issue_accept_i         (issue_accept_i),
    .level_o                (level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic set_idle();
    fetch_in_valid_i       = 1'b0;
    fetch_in_instr_i       = '0;
    fetch_in_pc_i          = '0;
    fetch_in_mask_i        = '0;
    fetch_in_pred_branch_i = '0;
    fetch_in_fault_fetch_i = 1'b0;
    fetch_in_fault_page_i  = 1'b0;
    flush_i                = 1'b0;
    issue_accept_i         = '0;
  endtask

  task automatic set_pkt(input logic [31:0] pc, input logic [FW-1:0] mask,
                         input logic [FW-1:0] pred, input logic ff, input logic fp);
    fetch_in_valid_i       = 1'b1;
    fetch_in_instr_i       = {$urandom, $urandom};
    fetch_in_pc_i          = pc;
    fetch_in_mask_i        = mask;
    fetch_in_pred_branch_i = pred;
    fetch_in_fault_fetch_i = ff;
    fetch_in_fault_page_i  = fp;
  endtask

  // Reference model: advance the queue by one clock from the driven inputs, then clock.
  task automatic tick();
    ent_t e;
    int   n;
    bit   room;
    bit   stop;
    if (flush_i) begin
      mq.delete();
    end else begin
      room = (DEPTH - mq.size()) >= FW;
      n = 0;
      while (n < IW && n < mq.size() && issue_accept_i[n]) n++;
      for (int i = 0; i < n; i++) void'(mq.pop_front());
      if (fetch_in_valid_i && room) begin
        if (fetch_in_fault_fetch_i || fetch_in_fault_page_i) begin
          e = '{instr: 32'h0, pc: fetch_in_pc_i, pred: 1'b0,
                ff: fetch_in_fault_fetch_i, fp: fetch_in_fault_page_i};
          mq.push_back(e);
        end else begin
          stop = 1'b0;
          for (int i = 0; i < FW; i++) begin
            if (!stop && fetch_in_mask_i[i]) begin
              e = '{instr: fetch_in_instr_i[32*i +: 32], pc: fetch_in_pc_i + 32'(4*i),
                    pred: fetch_in_pred_branch_i[i], ff: 1'b0, fp: 1'b0};
              mq.push_back(e);
              if (fetch_in_pred_branch_i[i]) stop = 1'b1;
            end
          end
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    set_idle();
    #3;
    vectors++;
    if (level_o !== '0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", level_o); end
    vectors++;
    if (issue_valid_o !== '0) begin miscompares++; $display("FAIL reset_valid: got %b want 00", issue_valid_o); end
    #5 rst_ni = 1'b1;
    tick();
    vectors++;
    if (fetch_in_accept_o !== 1'b1) begin miscompares++; $display("FAIL reset_accept: got %b want 1", fetch_in_accept_o); end
    // Build up five entries, then drop reset asynchronously mid-cycle.
    set_pkt(32'h80, 2'b11, 2'b00, 1'b0, 1'b0); tick();
    set_pkt(32'h88, 2'b11, 2'b00, 1'b0, 1'b0); tick();
    set_pkt(32'h90, 2'b01, 2'b00, 1'b0, 1'b0); tick();
    set_idle();
    vectors++;
    if (level_o !== 4'd5) begin miscompares++; $display("FAIL t1_level5: got %0d want 5", level_o); end
    #2 rst_ni = 1'b0;
    #1;
    mq.delete();
    vectors++;
    if (issue_valid_o !== '0) begin miscompares++; $display("FAIL t1_async_valid: got %b want 00", issue_valid_o); end
    vectors++;
    if (level_o !== '0) begin miscompares++; $display("FAIL t1_async_level: got %0d want 0", level_o); end
    #2 rst_ni = 1'b1;
    tick();
    vectors++;
    if (fetch_in_accept_o !== 1'b1) begin miscompares++; $display("FAIL t1_accept: got %b want 1", fetch_in_accept_o); end
  endtask

  task automatic test_fill_drain();
    for (int p = 0; p < 4; p++) begin
      vectors++;
      if (fetch_in_accept_o !== 1'b1) begin miscompares++; $display("FAIL fill_accept%0d: got %b want 1", p, fetch_in_accept_o); end
      set_pkt(32'h100 + 32'(8*p), 2'b11, 2'b00, 1'b0, 1'b0);
      tick();
    end
    set_idle();
    vectors++;
    if (level_o !== 4'd8) begin miscompares++; $display("FAIL fill_level: got %0d want 8", level_o); end
    vectors++;
    if (fetch_in_accept_o !== 1'b0) begin miscompares++; $display("FAIL full_accept: got %b want 0", fetch_in_accept_o); end
    issue_accept_i = 2'b11;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (issue_pc_o[31:0] !== 32'h100 + 32'(8*c)) begin
        miscompares++; $display("FAIL drain_pc0_%0d: got %h want %h", c, issue_pc_o[31:0], 32'h100 + 32'(8*c));
      end
      vectors++;
      if (issue_pc_o[63:32] !== 32'h104 + 32'(8*c)) begin
        miscompares++; $display("FAIL drain_pc1_%0d: got %h want %h", c, issue_pc_o[63:32], 32'h104 + 32'(8*c));
      end
      vectors++;
      if (issue_instr_o[31:0] !== mq[0].instr) begin
        miscompares++; $display("FAIL drain_instr_%0d: got %h want %h", c, issue_instr_o[31:0], mq[0].instr);
      end
      tick();
    end
    set_idle();
    vectors++;
    if (level_o !== '0 || issue_valid_o !== '0) begin
      miscompares++; $display("FAIL drain_empty: got level %0d valid %b want 0 00", level_o, issue_valid_o);
    end
  endtask

  task automatic test_mask_pred();
    set_pkt(32'h200, 2'b11, 2'b01, 1'b0, 1'b0); tick();
    set_idle();
    vectors++;
    if (level_o !== 4'd1) begin miscompares++; $display("FAIL pred_level: got %0d want 1", level_o); end
    vectors++;
    if (issue_pc_o[31:0] !== 32'h200 || issue_pred_branch_o[0] !== 1'b1) begin
      miscompares++; $display("FAIL pred_entry: got pc %h pred %b want 200 1", issue_pc_o[31:0], issue_pred_branch_o[0]);
    end
    set_pkt(32'h200, 2'b10, 2'b00, 1'b0, 1'b0); tick();
    set_idle();
    vectors++;
    if (level_o !== 4'd2) begin miscompares++; $display("FAIL mask_level: got %0d want 2", level_o); end
    vectors++;
    if (issue_pc_o[63:32] !== 32'h204 || issue_instr_o[63:32] !== mq[1].instr) begin
      miscompares++; $display("FAIL mask_entry: got pc %h want 204", issue_pc_o[63:32]);
    end
    issue_accept_i = 2'b11; tick(); set_idle();
  endtask

  task automatic test_partial_accept();
    set_pkt(32'h400, 2'b11, 2'b00, 1'b0, 1'b0); tick();
    set_pkt(32'h408, 2'b01, 2'b00, 1'b0, 1'b0); tick();
    set_idle();
    vectors++;
    if (level_o !== 4'd3) begin miscompares++; $display("FAIL pa_level3: got %0d want 3", level_o); end
    issue_accept_i = 2'b10; tick();
    vectors++;
    if (level_o !== 4'd3 || issue_pc_o[31:0] !== 32'h400) begin
      miscompares++; $display("FAIL pa_gap: got level %0d pc %h want 3 400", level_o, issue_pc_o[31:0]);
    end
    issue_accept_i = 2'b01; tick();
    set_idle();
    vectors++;
    if (level_o !== 4'd2) begin miscompares++; $display("FAIL pa_level2: got %0d want 2", level_o); end
    vectors++;
    if (issue_pc_o[31:0] !== 32'h404 || issue_pc_o[63:32] !== 32'h408) begin
      miscompares++; $display("FAIL pa_shift: got %h %h want 404 408", issue_pc_o[31:0], issue_pc_o[63:32]);
    end
    issue_accept_i = 2'b11; tick(); set_idle();
  endtask

  task automatic test_fault();
    set_pkt(32'h300, 2'b11, 2'b00, 1'b0, 1'b1); tick();
    set_pkt(32'h304, 2'b00, 2'b00, 1'b1, 1'b0); tick();
    set_idle();
    vectors++;
    if (level_o !== 4'd2) begin miscompares++; $display("FAIL fault_level: got %0d want 2", level_o); end
    vectors++;
    if ({issue_instr_o[31:0], issue_pc_o[31:0], issue_pred_branch_o[0], issue_fault_fetch_o[0], issue_fault_page_o[0]}
        !== {32'h0, 32'h300, 1'b0, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL fault_page_entry: got instr %h pc %h pred %b ff %b fp %b want 0 300 0 0 1",
                              issue_instr_o[31:0], issue_pc_o[31:0], issue_pred_branch_o[0],
                              issue_fault_fetch_o[0], issue_fault_page_o[0]);
    end
    vectors++;
    if (issue_pc_o[63:32] !== 32'h304 || issue_fault_fetch_o[1] !== 1'b1 || issue_fault_page_o[1] !== 1'b0) begin
      miscompares++; $display("FAIL fault_fetch_entry: got pc %h ff %b fp %b want 304 1 0",
                              issue_pc_o[63:32], issue_fault_fetch_o[1], issue_fault_page_o[1]);
    end
    issue_accept_i = 2'b11; tick(); set_idle();
  endtask

  task automatic test_flush();
    set_pkt(32'h600, 2'b11, 2'b00, 1'b0, 1'b0); tick();
    set_pkt(32'h608, 2'b11, 2'b00, 1'b0, 1'b0); tick();
    set_pkt(32'h610, 2'b11, 2'b00, 1'b0, 1'b0); tick();
    set_pkt(32'h618, 2'b01, 2'b00, 1'b0, 1'b0); tick();
    set_idle();
    vectors++;
    if (level_o !== 4'd7) begin miscompares++; $display("FAIL flush_level7: got %0d want 7", level_o); end
    set_pkt(32'h700, 2'b11, 2'b00, 1'b0, 1'b0);
    issue_accept_i = 2'b11;
    flush_i        = 1'b1;
    tick();
    set_idle();
    vectors++;
    if (level_o !== '0 || issue_valid_o !== '0 || fetch_in_accept_o !== 1'b1) begin
      miscompares++; $display("FAIL flush_after: got level %0d valid %b accept %b want 0 00 1",
                              level_o, issue_valid_o, fetch_in_accept_o);
    end
    set_pkt(32'h500, 2'b11, 2'b00, 1'b0, 1'b0); tick();
    set_idle();
    vectors++;
    if (issue_valid_o !== 2'b11 || issue_pc_o[31:0] !== 32'h500) begin
      miscompares++; $display("FAIL flush_restart: got valid %b pc %h want 11 500", issue_valid_o, issue_pc_o[31:0]);
    end
    issue_accept_i = 2'b11; tick(); set_idle();
  endtask

  task automatic test_random();
    ent_t          got;
    logic [IW-1:0] exp_v;
    bit            exp_acc;
    for (int c = 0; c < 400; c++) begin
      fetch_in_valid_i       = ($urandom_range(0, 3) != 0);
      fetch_in_instr_i       = {$urandom, $urandom};
      fetch_in_pc_i          = $urandom & 32'hFFFF_FFFC;
      fetch_in_mask_i        = FW'($urandom);
      fetch_in_pred_branch_i = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      fetch_in_fault_fetch_i = ($urandom_range(0, 15) == 0);
      fetch_in_fault_page_i  = ($urandom_range(0, 15) == 0);
      flush_i                = ($urandom_range(0, 31) == 0);
      issue_accept_i         = IW'($urandom);
      #1;
      exp_acc = (DEPTH - mq.size()) >= FW;
      for (int k = 0; k < IW; k++) exp_v[k] = (k < mq.size());
      vectors++;
      if (level_o !== 4'(mq.size())) begin
        miscompares++; $display("FAIL rnd_level c%0d: got %0d want %0d", c, level_o, mq.size());
      end
      vectors++;
      if (fetch_in_accept_o !== exp_acc) begin
        miscompares++; $display("FAIL rnd_accept c%0d: got %b want %b", c, fetch_in_accept_o, exp_acc);
      end
      vectors++;
      if (issue_valid_o !== exp_v) begin
        miscompares++; $display("FAIL rnd_valid c%0d: got %b want %b", c, issue_valid_o, exp_v);
      end
      for (int k = 0; k < IW; k++) begin
        if (k < mq.size()) begin
          got = '{instr: issue_instr_o[32*k +: 32], pc: issue_pc_o[32*k +: 32],
                  pred: issue_pred_branch_o[k], ff: issue_fault_fetch_o[k], fp: issue_fault_page_o[k]};
          vectors++;
          if (got !== mq[k]) begin
            miscompares++; $display("FAIL rnd_slot%0d c%0d: got %h want %h", k, c, got, mq[k]);
          end
        end
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_mask_pred();
    test_partial_accept();
    test_fault();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
